// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP payload filter.
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } frame_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 8 * BYTES_PER_WORD;

    // Index 0 starts a fresh word, so unfilled low bytes stay zero.
    function automatic logic [WORD_WIDTH-1:0] insert_byte(
        input logic [WORD_WIDTH-1:0] word,
        input logic [1:0]            idx,
        input logic [7:0]            b
    );
        logic [WORD_WIDTH-1:0] w;
        w = (idx == 2'd0) ? '0 : word;
        case (idx)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_next;
    logic [AW:0]      rd_ptr_next;
    logic             do_wr;
    logic             do_rd;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign do_rd       = rd_en && !empty;
    assign do_wr       = wr_en && (!full || do_rd);
    assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, do_wr};
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_rd};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            empty  <= (wr_ptr_next == rd_ptr_next);
            full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/udp_detector.sv
// Filters a byte-wide UDP payload stream by destination port and packs
// accepted bytes big-endian into 32-bit words buffered in a FWFT FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between frames; next valid beat decides accept or discard
// ACCEPT  | matching frame in progress, bytes are packed
// DISCARD | non-matching frame in progress, bytes are dropped
import udp_pkg::*;

module udp_detector #(
    parameter logic [15:0] LISTEN_PORT = 16'h1000,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dest_port,
    input  logic [7:0]  axis_tdata,
    input  logic        axis_tvalid,
    input  logic        axis_tlast,
    input  logic        rd_en,
    output logic        data_ready,
    output logic [31:0] data,
    output logic        full,
    output logic        empty
);

    frame_state_t          state;
    frame_state_t          state_next;
    logic                  accept_beat;
    logic                  word_done;
    logic [1:0]            byte_idx;
    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] word_next;
    logic [WORD_WIDTH-1:0] wr_word;
    logic                  wr_strobe;
    logic                  wr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept_beat = 1'b0;
        if (axis_tvalid) begin
            case (state)
                IDLE: begin
                    if (dest_port == LISTEN_PORT) begin
                        accept_beat = 1'b1;
                        state_next  = axis_tlast ? IDLE : ACCEPT;
                    end else begin
                        state_next  = axis_tlast ? IDLE : DISCARD;
                    end
                end
                ACCEPT: begin
                    accept_beat = 1'b1;
                    if (axis_tlast) state_next = IDLE;
                end
                DISCARD: begin
                    if (axis_tlast) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign word_next = insert_byte(acc, byte_idx, axis_tdata);
    assign word_done = accept_beat && ((byte_idx == 2'(BYTES_PER_WORD - 1)) || axis_tlast);

    // data_ready trails the write strobe by one cycle so it lines up with empty falling.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            acc        <= '0;
            wr_word    <= '0;
            wr_strobe  <= 1'b0;
            wr_last    <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            wr_strobe  <= word_done;
            wr_last    <= word_done && axis_tlast;
            data_ready <= wr_last;
            if (word_done) begin
                wr_word <= word_next;
            end
            if (accept_beat) begin
                if (word_done) begin
                    byte_idx <= 2'd0;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                    acc      <= word_next;
                end
            end else if (axis_tvalid && axis_tlast) begin
                byte_idx <= 2'd0;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_strobe),
        .din   (wr_word),
        .rd_en (rd_en),
        .dout  (data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_udp_detector.sv
// Self-checking bench for udp_detector: directed frames plus random frames
// compared against a frame-level packing model.
module tb_udp_detector;

    localparam logic [15:0] LP    = 16'h1000;
    localparam int          DEPTH = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic [15:0] dest_port;
    logic [7:0]  tdata;
    logic        valid;
    logic        tlast;
    logic        rd_en;
    logic        data_ready;
    logic [31:0] data;
    logic        full;
    logic        empty;

    int checks   = 0;
    int errors   = 0;
    int dr_count = 0;
    int exp_dr   = 0;
    logic [31:0] exp_q[$];

    udp_detector #(
        .LISTEN_PORT (LP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dest_port   (dest_port),
        .axis_tdata  (tdata),
        .axis_tvalid (valid),
        .axis_tlast  (tlast),
        .rd_en       (rd_en),
        .data_ready  (data_ready),
        .data        (data),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && data_ready === 1'b1) dr_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a matching frame becomes ceil(len/4) big-endian words, zero padded.
    task automatic model_frame(input logic [15:0] port, input bq_t b);
        if (port != LP) return;
        exp_dr++;
        for (int i = 0; i < b.size(); i += 4) begin
            logic [31:0] w;
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (i + k < b.size()) w = w | ({24'h0, b[i+k]} << (8 * (3 - k)));
            end
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
        end
    endtask

    task automatic send_frame(input logic [15:0] port, input bq_t b, input bit gaps);
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(1, 2)) begin
                    valid     = 1'b0;
                    tdata     = 8'($urandom);
                    tlast     = 1'($urandom);
                    dest_port = 16'($urandom);
                    step();
                end
            end
            valid     = 1'b1;
            tdata     = b[i];
            tlast     = (i == b.size() - 1);
            dest_port = (i == 0) ? port : (gaps ? ~port : port);
            step();
        end
        valid = 1'b0;
        tlast = 1'b0;
        model_frame(port, b);
    endtask

    task automatic drain(input string tag);
        repeat (2) step();
        while (exp_q.size() > 0) begin
            check({tag, " empty"}, {31'h0, empty}, 32'h0);
            check({tag, " data"}, data, exp_q.pop_front());
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check({tag, " empty after drain"}, {31'h0, empty}, 32'h1);
        check({tag, " data_ready count"}, dr_count, exp_dr);
    endtask

    initial begin
        bq_t f;
        logic [15:0] port;
        int len;

        rst = 1'b1; valid = 1'b0; tlast = 1'b0; tdata = 8'h00;
        dest_port = 16'h0; rd_en = 1'b0;
        repeat (15) step();
        check("reset empty", {31'h0, empty}, 32'h1);
        check("reset full", {31'h0, full}, 32'h0);
        check("reset data", data, 32'h0);
        check("reset data_ready", {31'h0, data_ready}, 32'h0);
        rst = 1'b0;
        step();

        // Basic 4-byte frame with latency checks
        f = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(LP, f, 1'b0);
        check("t1 empty at N", {31'h0, empty}, 32'h1);
        check("t1 data_ready at N", {31'h0, data_ready}, 32'h0);
        step();
        check("t1 empty at N+1", {31'h0, empty}, 32'h0);
        check("t1 data at N+1", data, 32'hDEADBEEF);
        check("t1 data_ready at N+1", {31'h0, data_ready}, 32'h1);
        step();
        check("t1 data_ready at N+2", {31'h0, data_ready}, 32'h0);
        repeat (2) step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        check("t1 empty after read", {31'h0, empty}, 32'h1);
        check("t1 data after read", data, 32'h0);
        check("t1 data_ready count", dr_count, exp_dr);

        // Non-matching port
        send_frame(16'h1001, f, 1'b0);
        repeat (3) step();
        check("t2 empty", {31'h0, empty}, 32'h1);
        check("t2 data_ready count", dr_count, exp_dr);

        // Six bytes: full word then padded word, one pulse after the second
        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(LP, f, 1'b0);
        check("t3 first word visible", data, 32'h01020304);
        check("t3 no early data_ready", dr_count, exp_dr - 1);
        drain("t3");

        // Same frame with gaps and dest_port toggling mid-frame
        send_frame(LP, f, 1'b1);
        drain("t4");

        // Random frame pairs sent back to back
        for (int n = 0; n < 20; n++) begin
            for (int p = 0; p < 2; p++) begin
                len = $urandom_range(1, 9);
                f.delete();
                repeat (len) f.push_back(8'($urandom));
                port = ($urandom_range(0, 1) == 1) ? LP : (LP ^ 16'($urandom_range(1, 16'hFFFF)));
                send_frame(port, f, 1'($urandom_range(0, 1)));
            end
            drain("rand");
        end

        // Overfill by one word
        for (int k = 0; k <= DEPTH; k++) begin
            f.delete();
            repeat (4) f.push_back(8'($urandom));
            send_frame(LP, f, 1'b0);
            if (k == DEPTH - 1) begin
                step();
                check("t6 full after DEPTH words", {31'h0, full}, 32'h1);
            end
        end
        repeat (2) step();
        check("t6 full after extra word", {31'h0, full}, 32'h1);
        drain("t6");
        rd_en = 1'b1;
        repeat (2) step();
        rd_en = 1'b0;
        check("t6 rd while empty: empty", {31'h0, empty}, 32'h1);
        check("t6 rd while empty: full", {31'h0, full}, 32'h0);
        check("t6 rd while empty: data", data, 32'h0);
        f = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(LP, f, 1'b0);
        drain("t6 after empty read");

        // Reset in the middle of a matching frame, with a word already buffered
        send_frame(LP, f, 1'b0);
        valid = 1'b1; tlast = 1'b0; dest_port = LP; tdata = 8'h11;
        step();
        tdata = 8'h22;
        step();
        valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("t7 empty after reset", {31'h0, empty}, 32'h1);
        check("t7 data after reset", data, 32'h0);
        check("t7 full after reset", {31'h0, full}, 32'h0);
        repeat (3) step();
        check("t7 data_ready count", dr_count, exp_dr);
        f = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(LP, f, 1'b0);
        drain("t7 clean frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
